// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR bus: edge-detected Read/Write
// requests, word-addressed RAM, fixed wait states and one-cycle
// Done/Error/Overrun pulses.
module mem_responder #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Busy,
  output logic              Error,
  output logic              Overrun
);

  localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT,
    WR_DONE
  } state_t;

  state_t              state_q;
  logic                read_q;
  logic                write_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   dout_q;
  logic                done_q;
  logic                busy_q;
  logic                err_q;
  logic                ovr_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic rd_rise;
  logic wr_rise;
  logic mem_we;

  // Request edges and the write-commit strobe (suppressed by reset so an
  // interrupted write never lands in the RAM).
  always_comb begin
    rd_rise = Read & ~read_q;
    wr_rise = Write & ~write_q;
    mem_we  = ~Reset && (state_q == WR_WAIT) && (cnt_q == '0);
  end

  // Request sequencer: capture, wait-state countdown, completion pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      read_q  <= Read;
      write_q <= Write;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // Any new edge outside IDLE (including the Done cycle) is dropped.
      ovr_q   <= (state_q != IDLE) && (rd_rise || wr_rise);
      case (state_q)
        IDLE: begin
          if (rd_rise && wr_rise) begin
            err_q <= 1'b1;
          end else if (rd_rise) begin
            addr_q  <= Address;
            cnt_q   <= RD_CNT;
            busy_q  <= 1'b1;
            state_q <= RD_WAIT;
          end else if (wr_rise) begin
            addr_q  <= Address;
            data_q  <= DataIn;
            cnt_q   <= WR_CNT;
            busy_q  <= 1'b1;
            state_q <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            dout_q  <= mem_q[addr_q];
            done_q  <= 1'b1;
            state_q <= RD_DONE;
          end
        end
        WR_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            done_q  <= 1'b1;
            state_q <= WR_DONE;
          end
        end
        RD_DONE, WR_DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign DataOut = dout_q;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign Error   = err_q;
  assign Overrun = ovr_q;

endmodule
